// File: rtl/z86_test_io.sv
// Simulated I/O port device for the z86 regression harness: latency-shaped completions,
// an 8-byte scratch window, a test-exit port and a drainable write log. Optional trace: Z86_TEST_IO_TRACE_EN.
module z86_test_io #(
  parameter int unsigned IO_LATENCY   = 2,
  parameter int unsigned LOG_DEPTH    = 16,
  parameter logic [15:0] SCRATCH_BASE = 16'h00E0,
  parameter logic [15:0] EXIT_PORT    = 16'h00F0
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        io_read_do,
  input  logic [15:0]                 io_read_address,
  input  logic                        io_read_word,
  output logic [15:0]                 io_read_data,
  output logic                        io_read_done,
  input  logic                        io_write_do,
  input  logic [15:0]                 io_write_address,
  input  logic                        io_write_word,
  input  logic [15:0]                 io_write_data,
  output logic                        io_write_done,
  input  logic                        dbg_log_rd,
  output logic [32:0]                 dbg_log_dout,
  output logic                        dbg_log_empty,
  output logic [$clog2(LOG_DEPTH):0]  dbg_log_count,
  output logic                        dbg_log_overflow,
  output logic                        protocol_err,
  output logic                        test_done,
  output logic [15:0]                 test_code
);
  localparam int unsigned AW    = $clog2(LOG_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_acc, wr_acc, err_set, rd_done_d, wr_done_d;
  logic [15:0]        rd_pend_q, rd_val;
  logic [7:0]         scratch_q [8];
  logic [32:0]        log_mem [LOG_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_d;
  logic               log_full, push_ok, pop_ok, push_drop;
  logic [15:0]        rd_off, wr_off;
  logic [2:0]         rd_i, wr_i;
  logic               rd_in, wr_in;

  assign rd_off = 16'(io_read_address - SCRATCH_BASE);
  assign wr_off = 16'(io_write_address - SCRATCH_BASE);
  assign rd_in  = rd_off < 16'd8;
  assign wr_in  = wr_off < 16'd8;
  assign rd_i   = rd_off[2:0];
  assign wr_i   = wr_off[2:0];

  // Read result is formed from scratch contents at acceptance time
  always_comb begin
    rd_val = 16'hFFFF;
    if (rd_in) begin
      if (io_read_word) rd_val = {scratch_q[3'(rd_i + 3'd1)], scratch_q[rd_i]};
      else              rd_val = {8'hFF, scratch_q[rd_i]};
    end
  end

  // Next-state logic; the cycle with cnt_q == 0 in a WAIT state is the done cycle and accepts like IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_acc  = 1'b0;
    wr_acc  = 1'b0;
    err_set = 1'b0;
    if (state_q == IDLE || cnt_q == '0) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (io_read_do) begin
        state_d = RD_WAIT;
        cnt_d   = CNT_W'(IO_LATENCY - 1);
        rd_acc  = 1'b1;
        err_set = io_write_do;
      end else if (io_write_do) begin
        state_d = WR_WAIT;
        cnt_d   = CNT_W'(IO_LATENCY - 1);
        wr_acc  = 1'b1;
      end
    end else begin
      cnt_d   = cnt_q - CNT_W'(1);
      err_set = io_read_do | io_write_do;
    end
    rd_done_d = (state_d == RD_WAIT) && (cnt_d == '0);
    wr_done_d = (state_d == WR_WAIT) && (cnt_d == '0);
  end

  assign log_full  = dbg_log_count == CW'(LOG_DEPTH);
  assign pop_ok    = dbg_log_rd && !dbg_log_empty;
  assign push_ok   = wr_acc && (!log_full || pop_ok);
  assign push_drop = wr_acc && log_full && !pop_ok;
  assign count_d   = dbg_log_count + CW'(push_ok) - CW'(pop_ok);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      rd_pend_q        <= 16'hFFFF;
      io_read_data     <= 16'hFFFF;
      io_read_done     <= 1'b0;
      io_write_done    <= 1'b0;
      for (int i = 0; i < 8; i++) scratch_q[i] <= 8'h00;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      dbg_log_count    <= '0;
      dbg_log_empty    <= 1'b1;
      dbg_log_overflow <= 1'b0;
      protocol_err     <= 1'b0;
      test_done        <= 1'b0;
      test_code        <= 16'h0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      io_read_done  <= rd_done_d;
      io_write_done <= wr_done_d;
      if (rd_acc) rd_pend_q <= rd_val;
      if (rd_done_d) io_read_data <= rd_acc ? rd_val : rd_pend_q;
      if (wr_acc && wr_in) begin
        scratch_q[wr_i] <= io_write_data[7:0];
        if (io_write_word) scratch_q[3'(wr_i + 3'd1)] <= io_write_data[15:8];
      end
      if (wr_acc && io_write_address == EXIT_PORT && !test_done) begin
        test_done <= 1'b1;
        test_code <= io_write_word ? io_write_data : {8'h00, io_write_data[7:0]};
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      dbg_log_count <= count_d;
      dbg_log_empty <= count_d == '0;
      if (push_drop) dbg_log_overflow <= 1'b1;
      if (err_set)   protocol_err     <= 1'b1;
    end
  end

  // Log storage needs no reset: the head is masked while empty
  always_ff @(posedge clk_sys) begin
    if (!reset && push_ok) log_mem[wr_ptr_q] <= {io_write_word, io_write_address, io_write_data};
  end

  assign dbg_log_dout = dbg_log_empty ? 33'd0 : log_mem[rd_ptr_q];

`ifdef Z86_TEST_IO_TRACE_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk_sys) begin
    if (reset) cyc_q <= '0;
    else begin
      cyc_q <= cyc_q + 32'd1;
      if (rd_acc) $display("[%0d] R %s port=%h data=%h", cyc_q, io_read_word ? "W" : "B", io_read_address, rd_val);
      if (wr_acc) $display("[%0d] W %s port=%h data=%h", cyc_q, io_write_word ? "W" : "B", io_write_address, io_write_data);
      if (err_set)   $display("[%0d] ERROR z86_test_io protocol violation", cyc_q);
      if (push_drop) $display("[%0d] ERROR z86_test_io write log overflow", cyc_q);
    end
  end
`endif

endmodule

// File: tb/tb_z86_test_io.sv
// Directed bench for z86_test_io: vector table of I/O transactions plus multi-cycle corner sequences.
module tb_z86_test_io;
  localparam int unsigned LAT = 3;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        io_read_do = 1'b0, io_read_word = 1'b0;
  logic [15:0] io_read_address = '0, io_read_data;
  logic        io_read_done;
  logic        io_write_do = 1'b0, io_write_word = 1'b0;
  logic [15:0] io_write_address = '0, io_write_data = '0;
  logic        io_write_done;
  logic        dbg_log_rd = 1'b0;
  logic [32:0] dbg_log_dout;
  logic        dbg_log_empty;
  logic [4:0]  dbg_log_count;
  logic        dbg_log_overflow, protocol_err, test_done;
  logic [15:0] test_code;

  int total = 0;
  int bad = 0;

  z86_test_io #(.IO_LATENCY(LAT), .LOG_DEPTH(16)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .io_read_do(io_read_do), .io_read_address(io_read_address), .io_read_word(io_read_word),
    .io_read_data(io_read_data), .io_read_done(io_read_done),
    .io_write_do(io_write_do), .io_write_address(io_write_address), .io_write_word(io_write_word),
    .io_write_data(io_write_data), .io_write_done(io_write_done),
    .dbg_log_rd(dbg_log_rd), .dbg_log_dout(dbg_log_dout), .dbg_log_empty(dbg_log_empty),
    .dbg_log_count(dbg_log_count), .dbg_log_overflow(dbg_log_overflow),
    .protocol_err(protocol_err), .test_done(test_done), .test_code(test_code)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit          wr;
    bit          word;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its done strobe; checks latency
  task automatic txn(input bit wr, input bit word, input logic [15:0] addr, input logic [15:0] data,
                     output logic [15:0] rdata);
    int n;
    n = 0;
    if (wr) begin
      io_write_do = 1'b1; io_write_word = word; io_write_address = addr; io_write_data = data;
    end else begin
      io_read_do = 1'b1; io_read_word = word; io_read_address = addr;
    end
    while (n < 20) begin
      tick();
      n++;
      io_read_do = 1'b0;
      io_write_do = 1'b0;
      if (wr ? io_write_done : io_read_done) break;
    end
    chk(wr ? "wr_latency" : "rd_latency", 33'(n), 33'(LAT));
    rdata = io_read_data;
  endtask

  task automatic pop_chk(input string name, input logic [32:0] exp);
    chk(name, dbg_log_dout, exp);
    dbg_log_rd = 1'b1;
    tick();
    dbg_log_rd = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_rd_data", 33'(io_read_data), 33'h0FFFF);
    chk("rst_rd_done", 33'(io_read_done), 33'd0);
    chk("rst_wr_done", 33'(io_write_done), 33'd0);
    chk("rst_empty", 33'(dbg_log_empty), 33'd1);
    chk("rst_count", 33'(dbg_log_count), 33'd0);
    chk("rst_dout", dbg_log_dout, 33'd0);
    chk("rst_ovf", 33'(dbg_log_overflow), 33'd0);
    chk("rst_err", 33'(protocol_err), 33'd0);
    chk("rst_tdone", 33'(test_done), 33'd0);
    chk("rst_tcode", 33'(test_code), 33'd0);
  endtask

  initial begin
    logic [15:0] rd;
    int rd_cnt, wr_cnt;

    vecs[0]  = '{0, 0, 16'h0060, 16'h0000, 16'hFFFF};
    vecs[1]  = '{1, 1, 16'h00E7, 16'hBEEF, 16'h0000};
    vecs[2]  = '{0, 1, 16'h00E7, 16'h0000, 16'hBEEF};
    vecs[3]  = '{0, 0, 16'h00E0, 16'h0000, 16'hFFBE};
    vecs[4]  = '{1, 0, 16'h00E3, 16'h5A55, 16'h0000};
    vecs[5]  = '{0, 1, 16'h00E2, 16'h0000, 16'h5500};
    vecs[6]  = '{0, 0, 16'h00E3, 16'h0000, 16'hFF55};
    vecs[7]  = '{0, 1, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[8]  = '{0, 1, 16'h00E8, 16'h0000, 16'hFFFF};
    vecs[9]  = '{0, 0, 16'h00DF, 16'h0000, 16'hFFFF};
    vecs[10] = '{1, 1, 16'h00E4, 16'hA1B2, 16'h0000};
    vecs[11] = '{0, 1, 16'h00E4, 16'h0000, 16'hA1B2};

    tick(); tick();
    reset = 1'b0;
    check_reset_vals();

    // Exact done timing for a read issued in cycle T
    io_read_do = 1'b1; io_read_word = 1'b0; io_read_address = 16'h0060;
    tick(); io_read_do = 1'b0;
    chk("lat_t1", 33'(io_read_done), 33'd0);
    tick();
    chk("lat_t2", 33'(io_read_done), 33'd0);
    tick();
    chk("lat_t3", 33'(io_read_done), 33'd1);
    chk("lat_data", 33'(io_read_data), 33'h0FFFF);
    tick();
    chk("lat_t4", 33'(io_read_done), 33'd0);

    foreach (vecs[i]) begin
      txn(vecs[i].wr, vecs[i].word, vecs[i].addr, vecs[i].data, rd);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), 33'(rd), 33'(vecs[i].exp));
    end

    chk("log_count3", 33'(dbg_log_count), 33'd3);
    pop_chk("log0", {1'b1, 16'h00E7, 16'hBEEF});
    pop_chk("log1", {1'b0, 16'h00E3, 16'h5A55});
    pop_chk("log2", {1'b1, 16'h00E4, 16'hA1B2});
    chk("log_empty", 33'(dbg_log_empty), 33'd1);

    // Collision in IDLE, then a write while busy
    chk("err_pre", 33'(protocol_err), 33'd0);
    io_read_do = 1'b1; io_read_word = 1'b1; io_read_address = 16'h00E7;
    io_write_do = 1'b1; io_write_word = 1'b1; io_write_address = 16'h00E0; io_write_data = 16'h1111;
    rd_cnt = 0; wr_cnt = 0;
    tick(); io_read_do = 1'b0; io_write_address = 16'h00E1;
    tick(); io_write_do = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rd_cnt += int'(io_read_done);
      wr_cnt += int'(io_write_done);
      tick();
    end
    chk("col_rd_done", 33'(rd_cnt), 33'd1);
    chk("col_wr_done", 33'(wr_cnt), 33'd0);
    chk("col_rdata", 33'(io_read_data), 33'h0BEEF);
    chk("col_log", 33'(dbg_log_count), 33'd0);
    chk("col_err", 33'(protocol_err), 33'd1);
    txn(0, 1, 16'h00E0, 16'h0000, rd);
    chk("col_no_side", 33'(rd), 33'h000BE);

    // Overflow: 17 writes into a 16-entry log
    for (int k = 0; k < 17; k++) txn(1, 1, 16'h0010 + 16'(k), 16'(k + 1), rd);
    chk("ovf_count", 33'(dbg_log_count), 33'd16);
    chk("ovf_flag", 33'(dbg_log_overflow), 33'd1);
    for (int k = 0; k < 16; k++) pop_chk($sformatf("ovf_pop%0d", k), {1'b1, 16'h0010 + 16'(k), 16'(k + 1)});
    chk("ovf_empty", 33'(dbg_log_empty), 33'd1);
    chk("ovf_count0", 33'(dbg_log_count), 33'd0);

    // Exit port: first write latches, later ones are ignored
    txn(1, 0, 16'h00F0, 16'h772A, rd);
    txn(1, 1, 16'h00F0, 16'h1234, rd);
    chk("exit_done", 33'(test_done), 33'd1);
    chk("exit_code", 33'(test_code), 33'h0002A);
    pop_chk("exit_log0", {1'b0, 16'h00F0, 16'h772A});
    pop_chk("exit_log1", {1'b1, 16'h00F0, 16'h1234});

    // Reset while in RD_WAIT aborts the read
    io_read_do = 1'b1; io_read_word = 1'b1; io_read_address = 16'h00E0;
    tick(); io_read_do = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      rd_cnt += int'(io_read_done);
      tick();
    end
    chk("abort_no_done", 33'(rd_cnt), 33'd0);
    check_reset_vals();
    txn(0, 1, 16'h00E0, 16'h0000, rd);
    chk("post_rst_rdata", 33'(rd), 33'h00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/z86_test_io.md
Name: z86_test_io

Overview:
- Simulated I/O port device for the z86 regression harness; consumes the CPU I/O read/write request channels and returns completion strobes and read data.
- Replaces a fixed "always FFFF, done next cycle" responder. Adds configurable latency, a scratch register window, a test-exit port and a write log that the bench drains.
- Sits beside the sdram simulation model in the test top; connects directly to the z86 io_* ports.

Parameters:
- IO_LATENCY, 2, cycles from request acceptance to the done strobe; legal range 1..15.
- LOG_DEPTH, 16, write-log FIFO entries; must be a power of 2, 2..256.
- SCRATCH_BASE, 16'h00E0, base port of the 8-byte scratch window.
- EXIT_PORT, 16'h00F0, test-exit port.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- io_read_do  in  1  single-cycle read request pulse.
- io_read_address  in  16  read port.
- io_read_word  in  1  1 = 16-bit access, 0 = 8-bit access.
- io_read_data  out  16  read result.
- io_read_done  out  1  read completion pulse.
- io_write_do  in  1  single-cycle write request pulse.
- io_write_address  in  16  write port.
- io_write_word  in  1  1 = 16-bit access, 0 = 8-bit access.
- io_write_data  in  16  write data.
- io_write_done  out  1  write completion pulse.
- dbg_log_rd  in  1  pop one write-log entry.
- dbg_log_dout  out  33  log head entry: {word, addr[15:0], data[15:0]}.
- dbg_log_empty  out  1  log is empty.
- dbg_log_count  out  $clog2(LOG_DEPTH)+1  current log occupancy.
- dbg_log_overflow  out  1  sticky flag: a log entry was dropped.
- protocol_err  out  1  sticky flag: request collision or request while busy.
- test_done  out  1  sticky flag: the exit port was written.
- test_code  out  16  data from the first exit-port write.

Behaviour:
- One clock domain. Reset is synchronous and active-high, and is named reset to match the codebase.
- Reset values:
  - state = IDLE, latency counter = 0.
  - All done outputs = 0, io_read_data = 16'hFFFF.
  - Scratch bytes = 8'h00.
  - Log empty: count = 0, dbg_log_empty = 1, dbg_log_dout = 0.
  - dbg_log_overflow, protocol_err, test_done = 0; test_code = 0.
- Reset mid-transaction aborts it; no done pulse is produced.
- State machine: IDLE, RD_WAIT, WR_WAIT.
  - In IDLE, io_read_do moves to RD_WAIT. Otherwise io_write_do moves to WR_WAIT.
  - On acceptance, the latency counter loads IO_LATENCY-1.
  - In each WAIT state the counter decrements. At 0, the matching done is pulsed for exactly one cycle and the state returns to IDLE.
  - Done therefore asserts exactly IO_LATENCY cycles after the cycle where do was high.
  - A new request is accepted in the cycle done is high.
- Simultaneous io_read_do and io_write_do in IDLE: the read is serviced, the write is dropped (no side effects, not logged), and protocol_err is set.
- Any do arriving while in RD_WAIT or WR_WAIT (and not in the done cycle) is dropped and sets protocol_err.
- Read data is computed at acceptance and registered. io_read_data is valid from the done cycle and held until the next read completes.
  - Port inside the window (addr - SCRATCH_BASE < 8), byte access: {8'hFF, scratch[i]}, where i = addr - SCRATCH_BASE.
  - Port inside the window, word access: {scratch[(i+1)&7], scratch[i]}; the index wraps within the window.
  - Any other port: 16'hFFFF, including byte accesses.
- Writes take effect at acceptance.
  - Scratch window, byte access: scratch[i] = data[7:0].
  - Scratch window, word access: scratch[i] = data[7:0], scratch[(i+1)&7] = data[15:8].
  - EXIT_PORT (byte or word): if test_done = 0, latch test_code = data (upper byte zeroed on byte writes) and set test_done. Later exit writes do not change test_code.
  - Other ports: no side effect.
- Write log: every accepted write, including scratch and exit writes, pushes {word, addr, data} in the acceptance cycle.
  - dbg_log_dout shows the head entry combinationally from FIFO storage.
  - dbg_log_rd pops the head.
  - Pop while empty is ignored.
  - Push while full, with no pop in the same cycle: the entry is dropped and dbg_log_overflow is set.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push and pop in the same cycle while empty: the push succeeds and the pop is ignored.
  - Pointers wrap modulo LOG_DEPTH.

Optional Feature:
- Macro: Z86_TEST_IO_TRACE_EN.
- Defined: every accepted read or write prints a $display line with cycle count, R/W, B/W, port and data. Every protocol_err or overflow event prints an error line.
- Undefined: no prints. Logic and port behaviour are identical in both cases.

Test Plan:
- IO_LATENCY=3, reset, then io_read_do to port 16'h0060 in cycle T -> io_read_done is high only in T+3, io_read_data = 16'hFFFF, state is IDLE at T+4.
- Word write 16'hBEEF to 16'h00E7, then word read of 16'h00E7 and byte read of 16'h00E0 -> reads return 16'hBEEF and 16'hFFBE; log holds {1, 00E7, BEEF}.
- io_read_do and io_write_do both high in IDLE; then io_write_do one cycle after acceptance with IO_LATENCY=3 -> one read done, no write done, no log entry, protocol_err = 1.
- 17 writes with LOG_DEPTH=16 and no pops -> count = 16, dbg_log_overflow = 1. Then pop 16 times -> entries 1..16 come out in order and dbg_log_empty = 1.
- Byte write 8'h2A to 16'h00F0, then word write 16'h1234 to 16'h00F0 -> test_done = 1, test_code = 16'h002A; both writes are logged.
- Assert reset in RD_WAIT -> no io_read_done, all outputs at reset values, the next request completes normally.
